// File: rtl/alu_datapath.sv
// Register-file ALU datapath: four registers, 8-op ALU, 4-entry FWFT output FIFO, sticky overflow.
// Latency: loads/pushes take effect on the next CLK edge; pushed data is on OUT_DATA one cycle later.
// Backpressure: OUT_VALID/OUT_READY; pushes into a full FIFO without a pop are dropped and set OVERFLOW.
// Optional ZERO/CARRY flag registers are built only when ALU_DATAPATH_FLAGS_EN is defined.

// Generic FWFT FIFO used for the datapath output queue.
// Latency: a push is visible at out_dat/out_vld after one edge.
// Backpressure: a push while full is accepted only with a same-cycle pop; otherwise drop_vld pulses.
module alu_datapath_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  output logic             drop_vld
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop;
  logic             wr;

  assign full     = (count == CW'(DEPTH));
  assign out_vld  = (count != '0);
  assign pop      = out_vld & pop_rdy;
  assign wr       = push_vld & (~full | pop);
  assign drop_vld = push_vld & full & ~pop;
  assign out_dat  = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= push_dat;
  end
endmodule

// Top-level datapath: operand muxing, ALU, register loads, push select and overflow tracking.
// Latency: one edge from CE/W to register/FIFO update; flags registered with the R2/R3 load.
// Backpressure: consumer stalls via OUT_READY; producer is never stalled, excess pushes set OVERFLOW.
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic [2:0]       W,
  input  logic [3:0]       CE,
  input  logic [1:0]       SEL,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] DIN_A,
  input  logic [WIDTH-1:0] DIN_B,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             CARRY
);
  logic [WIDTH-1:0] r0, r1, r2, r3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] push_dat;
  logic             drop_vld;
  logic             overflow_q;

  always_comb begin
    op_a = r0;
    case (SEL)
      2'b00: op_a = r0;
      2'b01: op_a = r3;
      2'b10: op_a = r1;
      2'b11: op_a = r2;
      default: op_a = r0;
    endcase
  end

  // Extended-width add/sub give carry-out and borrow in the top bit.
  assign sum_ext  = {1'b0, op_a} + {1'b0, r1};
  assign diff_ext = {1'b0, op_a} - {1'b0, r1};

  always_comb begin
    alu_res = op_a;
    case (S)
      3'b000: alu_res = op_a;
      3'b001: alu_res = sum_ext[WIDTH-1:0];
      3'b010: alu_res = diff_ext[WIDTH-1:0];
      3'b011: alu_res = op_a & r1;
      3'b100: alu_res = op_a | r1;
      3'b101: alu_res = op_a ^ r1;
      3'b110: alu_res = ~op_a;
      3'b111: alu_res = {op_a[WIDTH-2:0], 1'b0};
      default: alu_res = op_a;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (CLR) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (CE[0]) r0 <= DIN_A;
      if (CE[1]) r1 <= DIN_B;
      if (CE[2]) r2 <= alu_res;
      if (CE[3]) r3 <= alu_res;
    end
  end

`ifdef ALU_DATAPATH_FLAGS_EN
  logic alu_carry;
  logic zero_q;
  logic carry_q;

  always_comb begin
    alu_carry = 1'b0;
    case (S)
      3'b001:  alu_carry = sum_ext[WIDTH];
      3'b010:  alu_carry = diff_ext[WIDTH];
      3'b111:  alu_carry = op_a[WIDTH-1];
      default: alu_carry = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (CLR) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (CE[2] | CE[3]) begin
      zero_q  <= (alu_res == '0);
      carry_q <= alu_carry;
    end
  end

  assign ZERO  = zero_q;
  assign CARRY = carry_q;
`else
  assign ZERO  = 1'b0;
  assign CARRY = 1'b0;
`endif

  always_comb begin
    push_dat = r2;
    case (W[1:0])
      2'b00: push_dat = r2;
      2'b01: push_dat = r3;
      2'b10: push_dat = r0;
      2'b11: push_dat = r1;
      default: push_dat = r2;
    endcase
  end

  alu_datapath_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (4)
  ) u_out_fifo (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .push_vld (W[2]),
    .push_dat (push_dat),
    .pop_rdy  (OUT_READY),
    .out_dat  (OUT_DATA),
    .out_vld  (OUT_VALID),
    .drop_vld (drop_vld)
  );

  // CLR wins over a same-cycle dropped push so the clear is always clean.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      overflow_q <= 1'b0;
    else if (CLR)      overflow_q <= 1'b0;
    else if (drop_vld) overflow_q <= 1'b1;
  end

  assign OVERFLOW = overflow_q;
endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (WIDTH=8); flag expectations follow ALU_DATAPATH_FLAGS_EN.
module tb_alu_datapath;
  localparam int WIDTH = 8;
`ifdef ALU_DATAPATH_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             CLR;
  logic [2:0]       W;
  logic [3:0]       CE;
  logic [1:0]       SEL;
  logic [2:0]       S;
  logic [WIDTH-1:0] DIN_A;
  logic [WIDTH-1:0] DIN_B;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OVERFLOW;
  logic             ZERO;
  logic             CARRY;

  int n_cmp = 0;
  int n_bad = 0;

  alu_datapath #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CLR       (CLR),
    .W         (W),
    .CE        (CE),
    .SEL       (SEL),
    .S         (S),
    .DIN_A     (DIN_A),
    .DIN_B     (DIN_B),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVERFLOW  (OVERFLOW),
    .ZERO      (ZERO),
    .CARRY     (CARRY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock with the given controls; CLR/W/CE return to idle afterwards.
  task automatic cyc(input logic clr, input logic [2:0] w, input logic [3:0] ce,
                     input logic [1:0] sel, input logic [2:0] s);
    CLR = clr; W = w; CE = ce; SEL = sel; S = s;
    tick();
    CLR = 1'b0; W = 3'b000; CE = 4'b0000;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, {31'd0, OUT_VALID}, 32'd1);
    chk({tag, "_dat"}, {24'd0, OUT_DATA}, {24'd0, exp});
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic flags_chk(input string tag, input logic z, input logic c);
    chk({tag, "_zero"},  {31'd0, ZERO},  {31'd0, z & FL});
    chk({tag, "_carry"}, {31'd0, CARRY}, {31'd0, c & FL});
  endtask

  initial begin
    RESET_N = 1'b0; CLR = 1'b0; W = '0; CE = '0; SEL = '0; S = '0;
    DIN_A = '0; DIN_B = '0; OUT_READY = 1'b0;
    #12 RESET_N = 1'b1;
    #1;
    chk("rst_vld", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_ovf", {31'd0, OVERFLOW},  32'd0);
    flags_chk("rst", 1'b0, 1'b0);

    // Control sequence: R3 = 0x0A-0x03 = 0x07, then 0x07+0x03 = 0x0A, R2 = 0x0A+0x03 = 0x0D.
    DIN_A = 8'h0A; DIN_B = 8'h03;
    cyc(1'b1, 3'b000, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b000, 4'b0011, 2'b00, 3'b000);
    cyc(1'b0, 3'b000, 4'b1000, 2'b00, 3'b010);
    flags_chk("sub", 1'b0, 1'b0);
    chk("empty_vld", {31'd0, OUT_VALID}, 32'd0);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    chk("first_push_vld", {31'd0, OUT_VALID}, 32'd1);
    cyc(1'b0, 3'b000, 4'b1000, 2'b01, 3'b001);
    cyc(1'b0, 3'b101, 4'b0000, 2'b01, 3'b001);
    cyc(1'b0, 3'b100, 4'b0100, 2'b01, 3'b001);
    cyc(1'b0, 3'b100, 4'b0100, 2'b01, 3'b001);
    chk("seq_ovf", {31'd0, OVERFLOW}, 32'd0);
    pop_chk("seq_r3a", 8'h07);
    pop_chk("seq_r3b", 8'h0A);
    pop_chk("seq_r2a", 8'h00);
    pop_chk("seq_r2b", 8'h0D);
    chk("seq_drained", {31'd0, OUT_VALID}, 32'd0);

    // Fill: pushes R0 pre-edge = 0x0A,0x10,0x11,0x12; the fifth (0x13) is dropped.
    for (int i = 0; i < 5; i++) begin
      DIN_A = 8'(8'h10 + i);
      cyc(1'b0, 3'b110, 4'b0001, 2'b00, 3'b000);
      if (i == 3) chk("fill4_ovf", {31'd0, OVERFLOW}, 32'd0);
    end
    chk("fill5_ovf", {31'd0, OVERFLOW}, 32'd1);
    pop_chk("fill0", 8'h0A);
    pop_chk("fill1", 8'h10);
    pop_chk("fill2", 8'h11);
    pop_chk("fill3", 8'h12);
    chk("fill_drained", {31'd0, OUT_VALID}, 32'd0);
    chk("ovf_sticky", {31'd0, OVERFLOW}, 32'd1);
    cyc(1'b1, 3'b000, 4'b0000, 2'b00, 3'b000);
    chk("ovf_clr", {31'd0, OVERFLOW}, 32'd0);

    // Full with simultaneous push/pop: queue 00,20,21,22 then swap in 23,24.
    for (int i = 0; i < 4; i++) begin
      DIN_A = 8'(8'h20 + i);
      cyc(1'b0, 3'b110, 4'b0001, 2'b00, 3'b000);
    end
    OUT_READY = 1'b1;
    DIN_A = 8'h24;
    chk("pp_head0", {24'd0, OUT_DATA}, 32'h00);
    cyc(1'b0, 3'b110, 4'b0001, 2'b00, 3'b000);
    DIN_A = 8'h25;
    chk("pp_head1", {24'd0, OUT_DATA}, 32'h20);
    cyc(1'b0, 3'b110, 4'b0001, 2'b00, 3'b000);
    OUT_READY = 1'b0;
    chk("pp_ovf", {31'd0, OVERFLOW}, 32'd0);
    pop_chk("pp0", 8'h21);
    pop_chk("pp1", 8'h22);
    pop_chk("pp2", 8'h23);
    pop_chk("pp3", 8'h24);
    chk("pp_drained", {31'd0, OUT_VALID}, 32'd0);

    // Push and pop together at count 1.
    DIN_A = 8'h30;
    cyc(1'b0, 3'b110, 4'b0001, 2'b00, 3'b000);
    OUT_READY = 1'b1;
    cyc(1'b0, 3'b110, 4'b0000, 2'b00, 3'b000);
    OUT_READY = 1'b0;
    pop_chk("c1", 8'h30);
    chk("c1_drained", {31'd0, OUT_VALID}, 32'd0);

    // ALU ops and flags with R0=0xFF, R1=0x01, R2=R3=0.
    DIN_A = 8'hFF; DIN_B = 8'h01;
    cyc(1'b0, 3'b000, 4'b0011, 2'b00, 3'b000);
    cyc(1'b0, 3'b000, 4'b1000, 2'b00, 3'b001);
    flags_chk("add", 1'b1, 1'b1);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    flags_chk("hold", 1'b1, 1'b1);
    pop_chk("add", 8'h00);
    cyc(1'b0, 3'b000, 4'b1000, 2'b00, 3'b111);
    flags_chk("shl", 1'b0, 1'b1);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("shl", 8'hFE);
    cyc(1'b0, 3'b000, 4'b1000, 2'b11, 3'b010);
    flags_chk("borrow", 1'b0, 1'b1);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("borrow", 8'hFF);
    cyc(1'b0, 3'b000, 4'b0100, 2'b10, 3'b110);
    flags_chk("not", 1'b0, 1'b0);
    cyc(1'b0, 3'b100, 4'b0000, 2'b00, 3'b000);
    pop_chk("not", 8'hFE);
    cyc(1'b0, 3'b000, 4'b1000, 2'b10, 3'b101);
    flags_chk("xor", 1'b1, 1'b0);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("xor", 8'h00);
    cyc(1'b0, 3'b000, 4'b1000, 2'b00, 3'b011);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("and", 8'h01);
    cyc(1'b0, 3'b000, 4'b1000, 2'b11, 3'b100);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("or", 8'hFF);

    // CLR with CE=1111 while FIFO holds one entry.
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    cyc(1'b1, 3'b000, 4'b1111, 2'b00, 3'b001);
    flags_chk("clr", 1'b0, 1'b0);
    pop_chk("clr_keep", 8'hFF);
    chk("clr_cnt", {31'd0, OUT_VALID}, 32'd0);
    cyc(1'b0, 3'b110, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b111, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b100, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b101, 4'b0000, 2'b00, 3'b000);
    pop_chk("clr_r0", 8'h00);
    pop_chk("clr_r1", 8'h00);
    pop_chk("clr_r2", 8'h00);
    pop_chk("clr_r3", 8'h00);

    // Asynchronous reset mid-cycle with two entries queued and ZERO set.
    cyc(1'b0, 3'b110, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b110, 4'b0000, 2'b00, 3'b000);
    cyc(1'b0, 3'b000, 4'b1000, 2'b00, 3'b000);
    flags_chk("pre_rst", 1'b1, 1'b0);
    #3 RESET_N = 1'b0;
    #1;
    chk("arst_vld", {31'd0, OUT_VALID}, 32'd0);
    chk("arst_ovf", {31'd0, OVERFLOW},  32'd0);
    flags_chk("arst", 1'b0, 1'b0);
    #2 RESET_N = 1'b1;
    tick();
    chk("post_rst_vld", {31'd0, OUT_VALID}, 32'd0);
    DIN_A = 8'h5A;
    cyc(1'b0, 3'b000, 4'b0001, 2'b00, 3'b000);
    chk("post_rst_nopush", {31'd0, OUT_VALID}, 32'd0);
    cyc(1'b0, 3'b110, 4'b0000, 2'b00, 3'b000);
    pop_chk("post_rst", 8'h5A);
    chk("post_rst_drained", {31'd0, OUT_VALID}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
